// File: rtl/hpm_window_sampler_if.sv
// rtl/hpm_window_sampler_if.sv - snapshot/handoff bundle between window sampler and detector
interface hpm_window_sampler_if;
    logic [1:0][31:0] hpm_o;
    logic             enable_d_o;
    logic             end_d_i;
    logic [1:0]       alert_i;

    modport master (output hpm_o, output enable_d_o, input end_d_i, input alert_i);
    modport slave  (input hpm_o, input enable_d_o, output end_d_i, output alert_i);
endinterface

// File: rtl/hpm_window_sampler.sv
// rtl/hpm_window_sampler.sv - windowed imiss/jump-stall counter feeding the detector handoff
// Optional feature: DIWALL_ALERT_IRQ_EN enables the sticky attack interrupt irq_o.
module hpm_window_sampler #(
    parameter int unsigned WINDOW_LEN = 1024,
    parameter int unsigned ATK_CNT_W  = 16
) (
    input  logic                 clk_h,
    input  logic                 rst_h,
    input  logic                 sample_en_i,
    input  logic                 imiss_i,
    input  logic                 jmp_stall_i,
    hpm_window_sampler_if.master det,
    output logic [1:0]           last_alert_o,
    output logic [ATK_CNT_W-1:0] attack_cnt_o,
    output logic                 overrun_o,
    output logic                 irq_o,
    input  logic                 irq_clr_i
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [31:0] LAST_TICK = 32'(WINDOW_LEN - 1);

    state_t      state;
    logic [31:0] timer;
    logic [31:0] imiss_cnt;
    logic [31:0] jmp_cnt;

    logic        counting;
    logic        win_close;
    logic        done;
    logic        attack;
    logic [31:0] imiss_nxt;
    logic [31:0] jmp_nxt;

    assign counting  = (state != IDLE) && sample_en_i;
    assign win_close = counting && (timer == LAST_TICK);
    assign done      = (state == PEND) && det.end_d_i;
    assign attack    = done && (det.alert_i != 2'b00);
    // the closing cycle's own strobes belong to the window being snapshotted
    assign imiss_nxt = imiss_cnt + 32'(imiss_i);
    assign jmp_nxt   = jmp_cnt + 32'(jmp_stall_i);

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state          <= IDLE;
            timer          <= '0;
            imiss_cnt      <= '0;
            jmp_cnt        <= '0;
            det.hpm_o      <= '0;
            det.enable_d_o <= 1'b0;
            last_alert_o   <= 2'b00;
            attack_cnt_o   <= '0;
            overrun_o      <= 1'b0;
        end else begin
            det.enable_d_o <= 1'b0;

            if (counting && !win_close) begin
                timer     <= timer + 32'd1;
                imiss_cnt <= imiss_nxt;
                jmp_cnt   <= jmp_nxt;
            end else begin
                timer     <= '0;
                imiss_cnt <= '0;
                jmp_cnt   <= '0;
            end

            if (done) begin
                last_alert_o <= det.alert_i;
                if (attack && (attack_cnt_o != '1)) begin
                    attack_cnt_o <= attack_cnt_o + ATK_CNT_W'(1);
                end
            end

            // a completion in the closing cycle frees the slot for this snapshot
            if (win_close && ((state == RUN) || done)) begin
                det.hpm_o      <= {imiss_nxt, jmp_nxt};
                det.enable_d_o <= 1'b1;
            end

            if (win_close && (state == PEND) && !done) begin
                overrun_o <= 1'b1;
            end else if (irq_clr_i) begin
                overrun_o <= 1'b0;
            end

            case (state)
                IDLE: if (sample_en_i) state <= RUN;
                RUN: begin
                    if (win_close)         state <= PEND;
                    else if (!sample_en_i) state <= IDLE;
                end
                PEND: begin
                    if (done && !win_close) state <= sample_en_i ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIWALL_ALERT_IRQ_EN
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            irq_o <= 1'b0;
        end else if (attack) begin
            irq_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_o <= 1'b0;
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_window_sampler.sv
// tb/tb_hpm_window_sampler.sv - bench for hpm_window_sampler (WINDOW_LEN=8, ATK_CNT_W=4)
module tb_hpm_window_sampler;

    localparam int W    = 8;
    localparam int AW   = 4;
    localparam int AMAX = (1 << AW) - 1;
`ifdef DIWALL_ALERT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk_h = 1'b0;
    logic          rst_h;
    logic          sample_en_i, imiss_i, jmp_stall_i, irq_clr_i;
    logic [1:0]    last_alert_o;
    logic [AW-1:0] attack_cnt_o;
    logic          overrun_o, irq_o;

    hpm_window_sampler_if dif ();

    hpm_window_sampler #(.WINDOW_LEN(W), .ATK_CNT_W(AW)) dut (
        .clk_h        (clk_h),
        .rst_h        (rst_h),
        .sample_en_i  (sample_en_i),
        .imiss_i      (imiss_i),
        .jmp_stall_i  (jmp_stall_i),
        .det          (dif),
        .last_alert_o (last_alert_o),
        .attack_cnt_o (attack_cnt_o),
        .overrun_o    (overrun_o),
        .irq_o        (irq_o),
        .irq_clr_i    (irq_clr_i)
    );

    always #5 clk_h = ~clk_h;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: windows measured in elapsed cycles, handoff as a busy flag.
    bit     m_active, m_pend, m_en, m_irq, m_ovr;
    bit     p1, p2;
    int     m_elapsed, m_last, m_atk;
    longint m_ci, m_cj, m_hi, m_hj;

    function automatic void model_reset();
        m_active = 0; m_pend = 0; m_en = 0; m_irq = 0; m_ovr = 0;
        p1 = 0; p2 = 0;
        m_elapsed = 0; m_last = 0; m_atk = 0;
        m_ci = 0; m_cj = 0; m_hi = 0; m_hj = 0;
    endfunction

    function automatic void model_step();
        bit done, set_irq, set_ovr;
        done = 0; set_irq = 0; set_ovr = 0;
        p2 = p1;
        p1 = m_en;
        m_en = 0;
        if (!rst_h) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (sample_en_i) m_active = 1;
        end else begin
            done = m_pend && dif.end_d_i;
            if (done) begin
                m_last = int'(dif.alert_i);
                if (dif.alert_i != 2'b00) begin
                    set_irq = 1;
                    if (m_atk < AMAX) m_atk++;
                end
                m_pend = 0;
            end
            if (sample_en_i) begin
                m_ci += longint'(imiss_i);
                m_cj += longint'(jmp_stall_i);
                m_elapsed++;
                if (m_elapsed == W) begin
                    if (m_pend) set_ovr = 1;
                    else begin
                        m_hi = m_ci; m_hj = m_cj; m_en = 1; m_pend = 1;
                    end
                    m_elapsed = 0; m_ci = 0; m_cj = 0;
                end
            end else begin
                m_elapsed = 0; m_ci = 0; m_cj = 0;
                if (!m_pend) m_active = 0;
            end
        end
        m_irq = set_irq ? 1'b1 : (irq_clr_i ? 1'b0 : m_irq);
        m_ovr = set_ovr ? 1'b1 : (irq_clr_i ? 1'b0 : m_ovr);
    endfunction

    task automatic check_model();
        chk("enable_d_o", longint'(dif.enable_d_o), longint'(m_en));
        chk("hpm_imiss", longint'(dif.hpm_o[1]), m_hi);
        chk("hpm_jmp", longint'(dif.hpm_o[0]), m_hj);
        chk("last_alert", longint'(last_alert_o), longint'(m_last));
        chk("attack_cnt", longint'(attack_cnt_o), longint'(m_atk));
        chk("overrun", longint'(overrun_o), longint'(m_ovr));
        chk("irq", longint'(irq_o), longint'(IRQ_ON && m_irq));
    endtask

    task automatic set_in(input bit en, input bit im, input bit js, input bit ed,
                          input bit [1:0] al, input bit clr);
        sample_en_i = en; imiss_i = im; jmp_stall_i = js;
        dif.end_d_i = ed; dif.alert_i = al; irq_clr_i = clr;
    endtask

    task automatic cyc();
        @(posedge clk_h);
        model_step();
        #1;
        check_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hpm"}, longint'(dif.hpm_o), 0);
        chk({tag, "_enable"}, longint'(dif.enable_d_o), 0);
        chk({tag, "_last"}, longint'(last_alert_o), 0);
        chk({tag, "_atk"}, longint'(attack_cnt_o), 0);
        chk({tag, "_ovr"}, longint'(overrun_o), 0);
        chk({tag, "_irq"}, longint'(irq_o), 0);
    endtask

    typedef struct {
        bit en, im, js, ed; bit [1:0] al; bit clr;
        bit x_en; int x_hi, x_hj; bit [1:0] x_last; int x_atk; bit x_irq, x_ovr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int first_pulse;
        tbl[0]  = '{1,0,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[1]  = '{1,1,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[2]  = '{1,1,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[3]  = '{1,0,1,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[4]  = '{1,1,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[5]  = '{1,0,1,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[6]  = '{1,1,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[7]  = '{1,0,0,0,2'd0,0, 0,0,0,2'd0,0,0,0};
        tbl[8]  = '{1,1,1,0,2'd0,0, 1,5,3,2'd0,0,0,0};
        tbl[9]  = '{1,1,0,0,2'd0,0, 0,5,3,2'd0,0,0,0};
        tbl[10] = '{1,0,0,0,2'd0,0, 0,5,3,2'd0,0,0,0};
        tbl[11] = '{1,0,0,1,2'd2,0, 0,5,3,2'd2,1,1,0};
        tbl[12] = '{1,0,0,0,2'd0,1, 0,5,3,2'd2,1,0,0};
        tbl[13] = '{1,0,0,0,2'd0,0, 0,5,3,2'd2,1,0,0};
        tbl[14] = '{1,0,0,0,2'd0,0, 0,5,3,2'd2,1,0,0};
        tbl[15] = '{1,0,0,0,2'd0,0, 0,5,3,2'd2,1,0,0};
        tbl[16] = '{1,0,1,0,2'd0,0, 1,1,1,2'd2,1,0,0};
        tbl[17] = '{1,0,0,0,2'd0,0, 0,1,1,2'd2,1,0,0};

        rst_h = 1'b0;
        set_in(0,0,0,0,2'd0,0);
        model_reset();
        repeat (2) @(posedge clk_h);
        #1;
        chk_all_zero("reset");
        rst_h = 1'b1;

        // first windows, detector answer, irq clear, boundary events
        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].im, tbl[i].js, tbl[i].ed, tbl[i].al, tbl[i].clr);
            cyc();
            chk($sformatf("tbl%0d_enable", i), longint'(dif.enable_d_o), longint'(tbl[i].x_en));
            chk($sformatf("tbl%0d_hpm_imiss", i), longint'(dif.hpm_o[1]), longint'(tbl[i].x_hi));
            chk($sformatf("tbl%0d_hpm_jmp", i), longint'(dif.hpm_o[0]), longint'(tbl[i].x_hj));
            chk($sformatf("tbl%0d_last", i), longint'(last_alert_o), longint'(tbl[i].x_last));
            chk($sformatf("tbl%0d_atk", i), longint'(attack_cnt_o), longint'(tbl[i].x_atk));
            chk($sformatf("tbl%0d_irq", i), longint'(irq_o), longint'(IRQ_ON && tbl[i].x_irq));
            chk($sformatf("tbl%0d_ovr", i), longint'(overrun_o), longint'(tbl[i].x_ovr));
        end

        // stalled detector: window 3 overruns, window 4 close coincides with end_d_i
        for (int i = 0; i < 7; i++) begin set_in(1,1,0,0,2'd0,0); cyc(); end
        chk("ovr_set", longint'(overrun_o), 1);
        chk("ovr_hpm_hold_imiss", longint'(dif.hpm_o[1]), 1);
        chk("ovr_hpm_hold_jmp", longint'(dif.hpm_o[0]), 1);
        chk("ovr_no_pulse", longint'(dif.enable_d_o), 0);
        for (int i = 0; i < 7; i++) begin set_in(1,0,1,0,2'd0,0); cyc(); end
        set_in(1,0,1,1,2'd0,0); cyc();
        chk("coinc_pulse", longint'(dif.enable_d_o), 1);
        chk("coinc_hpm_imiss", longint'(dif.hpm_o[1]), 0);
        chk("coinc_hpm_jmp", longint'(dif.hpm_o[0]), 8);
        chk("coinc_ovr_kept", longint'(overrun_o), 1);
        set_in(1,0,0,0,2'd0,1); cyc();
        chk("ovr_clear", longint'(overrun_o), 0);

        // responsive detector always reporting stack attacks: counter saturates
        for (int i = 0; i < 170; i++) begin
            set_in(1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), p2, 2'd2, 0);
            cyc();
        end
        chk("atk_saturated", longint'(attack_cnt_o), AMAX);
        chk("atk_sat_irq", longint'(irq_o), longint'(IRQ_ON));

        // reset while a handoff is pending; late end_d_i must be ignored
        for (int i = 0; i < 20 && !(m_pend && !m_en); i++) begin
            set_in(1,0,0,0,2'd0,0); cyc();
        end
        chk("pend_before_reset", longint'(m_pend), 1);
        #3 rst_h = 1'b0;
        #1 chk_all_zero("async_reset");
        cyc();
        rst_h = 1'b1;
        set_in(0,0,0,1,2'd3,0); cyc();
        chk_all_zero("late_end_d");
        first_pulse = -1;
        for (int i = 0; i < 20 && first_pulse < 0; i++) begin
            set_in(1,0,0,0,2'd0,0); cyc();
            if (dif.enable_d_o) first_pulse = i;
        end
        chk("first_pulse_latency", longint'(first_pulse), W);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit stall, spur;
            bit [1:0] al;
            stall = ($urandom_range(0,7) == 0);
            spur  = ($urandom_range(0,31) == 0);
            case ($urandom_range(0,3))
                0: al = 2'd0;
                1: al = 2'd2;
                2: al = 2'd3;
                default: al = 2'd0;
            endcase
            set_in($urandom_range(0,31) != 0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                   (p2 && !stall) || spur, al, $urandom_range(0,15) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hpm_window_sampler.md
# hpm_window_sampler

Upstream feeder for the Detector classification stage. Counts two core performance events (instruction-cache miss and jump stall) over fixed windows of WINDOW_LEN cycles. At each window close it snapshots both counts onto `hpm_o` and issues a one-cycle `enable_d_o` pulse. It then waits for the detector's `end_d_i` completion strobe, latches the returned alert class, and keeps attack statistics for software.

## Interface
- `WINDOW_LEN`, default 1024: window length in clk_h cycles; legal range 4..2^31.
- `ATK_CNT_W`, default 16: width of the attack counter.

- `clk_h`  in  1  clock.
- `rst_h`  in  1  reset; asynchronous, active-low; clock is clk_h.
- `sample_en_i`  in  1  global monitoring enable.
- `imiss_i`  in  1  one-cycle event strobe, instruction miss.
- `jmp_stall_i`  in  1  one-cycle event strobe, jump stall.
- `hpm_o`  out  [1:0][31:0]  snapshot to the detector; [1] = imiss count, [0] = jmp_stall count.
- `enable_d_o`  out  1  detector start pulse.
- `end_d_i`  in  1  detector done strobe.
- `alert_i`  in  2  detector class: 00 = legit, 10 = stack, 11 = heap.
- `last_alert_o`  out  2  alert_i captured at the last end_d_i.
- `attack_cnt_o`  out  ATK_CNT_W  count of non-zero alerts; saturates at all-ones.
- `overrun_o`  out  1  sticky flag: a window closed while a handoff was pending.
- `irq_o`  out  1  sticky attack interrupt.
- `irq_clr_i`  in  1  clears irq_o and overrun_o.

## Operation
- States:
  - IDLE: sample_en_i = 0; timer and live counters held at 0.
  - RUN: counting, no handoff outstanding.
  - PEND: pulse issued, awaiting end_d_i.
- Transitions:
  - IDLE→RUN when sample_en_i = 1.
  - RUN→IDLE when sample_en_i = 0. Timer and live counters clear; hpm_o holds.
- Counting (RUN and PEND with sample_en_i = 1):
  - Window timer counts 0..WINDOW_LEN-1.
  - Live counters add 1 per event strobe; 32-bit, cannot overflow within a legal window.
- Window close (timer = WINDOW_LEN-1):
  - Snapshot value = live count plus any event in the closing cycle.
  - Live counters and timer restart at 0 on the next cycle, with no lost events.
- Close in RUN:
  - hpm_o updates at that clock edge.
  - enable_d_o is high for exactly the following cycle.
  - State → PEND.
- Close in PEND: overrun.
  - Snapshot discarded; hpm_o is unchanged.
  - Live counters still restart.
  - overrun_o is set; state remains PEND; no new pulse.
- end_d_i = 1 in PEND:
  - last_alert_o ← alert_i.
  - If alert_i ≠ 00, attack_cnt_o increments (saturating) and irq_o is set.
  - State → RUN, or IDLE if sample_en_i = 0.
- end_d_i outside PEND: ignored.
- end_d_i and window close in the same cycle while in PEND:
  - The completion is processed first.
  - The new snapshot is then handed off (new pulse, stay PEND).
  - No overrun is flagged.
- sample_en_i = 0 while in PEND:
  - Timer and counters freeze at 0.
  - The pending handoff still completes; then state → IDLE.
- irq_clr_i clears irq_o and overrun_o. A simultaneous set wins over the clear.

## Timing
- Reset values: hpm_o = 0, enable_d_o = 0, last_alert_o = 00, attack_cnt_o = 0, overrun_o = 0, irq_o = 0. State = IDLE, timer = 0, counters = 0.
- All outputs are registered.
- enable_d_o is never high for two consecutive cycles, because a held-high enable would make the detector re-analyze.
- Pulse at cycle T → detector samples it and raises end_d_i at T+2. last_alert_o, attack_cnt_o and irq_o update at the edge ending T+2.
- First pulse: WINDOW_LEN cycles after the IDLE→RUN transition.
- WINDOW_LEN ≥ 4 guarantees handoff completion before the next close with a responsive detector.
- Reset mid-PEND: all state clears immediately. A late end_d_i after reset is ignored.

## Configuration
- `DIWALL_ALERT_IRQ_EN`:
  - Defined: irq_o behaves as above.
  - Undefined: irq_o is tied to 0 and irq_clr_i clears only overrun_o.
- attack_cnt_o and last_alert_o are unaffected by the macro either way.

## Test plan
- WINDOW_LEN = 8, imiss_i pulsed 5 times and jmp_stall_i 3 times in window 1 → hpm_o = {5, 3}; one-cycle enable_d_o exactly 8 cycles after enable.
- Model detector returns alert 10 at T+2 → last_alert_o = 10, attack_cnt_o = 1, irq_o = 1; irq_clr_i → irq_o = 0.
- Events asserted on the closing cycle and on the first cycle of the next window → counted in window N and window N+1 respectively; none lost.
- Detector stalled (no end_d_i) for 2 windows → overrun_o = 1, hpm_o unchanged, no extra pulse. end_d_i coinciding with the next close → new pulse, overrun_o unchanged.
- 0xFFFF+2 non-zero alerts with ATK_CNT_W = 16 → attack_cnt_o stays 0xFFFF.
- rst_h asserted in PEND, then end_d_i = 1 after release → all outputs 0 and state IDLE; attack_cnt_o remains 0.
